ro_meas_ctrl: RTL and testbench

Measurement controller for the on-chip ring-oscillator bank. It enables one gated ring oscillator at a time and lets it settle. It then counts the oscillator's rising edges over a programmable window of system-clock cycles and reports a saturating count per oscillator. It sits between the control/CSR logic and the `ro_en`/`ro_q` pins of the ring-oscillator instances, either for a single selected oscillator or as a sweep of all of them.

---
 rtl/ro_pkg.sv | 15 +
 rtl/ro_edge_sync.sv | 28 ++
 rtl/ro_meas_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ro_meas_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DRAIN,
    REPORT
  } ro_meas_state_e;

  localparam int RO_DRAIN_CYC   = 2;
  localparam int RO_SYNC_STAGES = 2;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizer plus rising-edge detect for the selected ring-oscillator output.
module ro_edge_sync
  import ro_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic async_i,
  output logic rise_o
);

  logic [RO_SYNC_STAGES-1:0] sync_p0;
  logic                      edge_p1;

  // Stage boundary: metastability chain, then one flop of history for edge detect
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sync_p0 <= '0;
      edge_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[RO_SYNC_STAGES-2:0], async_i};
      edge_p1 <= sync_p0[RO_SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_p0[RO_SYNC_STAGES-1] & ~edge_p1;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: settle, count edges over a window,
// flush the synchronizer and report a saturating count, singly or as a sweep.
module ro_meas_ctrl
  import ro_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  localparam int IDX_W     = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              sweep_i,
  input  logic [IDX_W-1:0]  ro_sel_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic              abort_i,
  input  logic [NUM_RO-1:0] ro_q_i,
  output logic [NUM_RO-1:0] ro_en_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [IDX_W-1:0]  result_idx_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TMR_W = (WIN_W > $clog2(SETTLE_CYC + 1)) ? WIN_W : $clog2(SETTLE_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_DRAIN  = TMR_W'(RO_DRAIN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_RO - 1);

  ro_meas_state_e    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              sweep_q;
  logic [WIN_W-1:0]  win_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [CNT_W:0]    cnt_inc;
  logic              accept, enter_settle, enter_report, err_d, last;
  logic              rise;

  // Returns {overflow_attempt, next_count}; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  function automatic logic [NUM_RO-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_RO-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_RO; k++) v[k] = (32'(i) == k);
    return v;
  endfunction

  assign last    = !sweep_q || (idx_q == IDX_LAST);
  assign cnt_inc = sat_inc(cnt_q);
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    accept       = 1'b0;
    enter_settle = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!sweep_i && (32'(ro_sel_i) >= NUM_RO)) begin
            err_d = 1'b1;
          end else begin
            accept       = 1'b1;
            enter_settle = 1'b1;
            state_d      = SETTLE;
            idx_d        = sweep_i ? '0 : ro_sel_i;
            tmr_d        = TMR_SETTLE;
          end
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          if (win_q == '0) begin
            state_d = DRAIN;
            tmr_d   = TMR_DRAIN;
          end else begin
            state_d = MEASURE;
            tmr_d   = TMR_W'(win_q) - TMR_ONE;
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      MEASURE: begin
        if (tmr_q == '0) begin
          state_d = DRAIN;
          tmr_d   = TMR_DRAIN;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) state_d = REPORT;
        else             tmr_d   = tmr_q - TMR_ONE;
      end
      REPORT: begin
        if (!last) begin
          state_d      = SETTLE;
          idx_d        = idx_q + IDX_W'(1);
          enter_settle = 1'b1;
          tmr_d        = TMR_SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d      = IDLE;
      idx_d        = idx_q;
      enter_settle = 1'b0;
    end
    enter_report = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Mux ahead of the synchronizer; cleared on every SETTLE entry
  ro_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (enter_settle),
    .async_i(ro_q_i[idx_q]),
    .rise_o (rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q          <= '0;
      tmr_q          <= '0;
      sweep_q        <= 1'b0;
      win_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      ro_en_o        <= '0;
      result_valid_o <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      count_o        <= '0;
      ovf_o          <= 1'b0;
      result_idx_o   <= '0;
    end else begin
      idx_q <= idx_d;
      tmr_q <= tmr_d;
      if (accept) begin
        sweep_q <= sweep_i;
        win_q   <= win_len_i;
      end
      if (enter_settle) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if ((state_q == MEASURE) && rise) begin
        cnt_q <= cnt_inc[CNT_W-1:0];
        ovf_q <= ovf_q | cnt_inc[CNT_W];
      end
      ro_en_o        <= ((state_d == SETTLE) || (state_d == MEASURE)) ? onehot(idx_d) : '0;
      result_valid_o <= enter_report;
      done_o         <= enter_report && last;
      err_o          <= err_d;
      if (enter_report) begin
        count_o      <= cnt_q;
        ovf_o        <= ovf_q;
        result_idx_o <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Scoreboard bench for ro_meas_ctrl: stimulus pushes predicted results, a monitor checks them.
module tb_ro_meas_ctrl;

  localparam int NUM_RO     = 5;
  localparam int CNT_W      = 5;
  localparam int WIN_W      = 8;
  localparam int SETTLE_CYC = 8;
  localparam int IDX_W      = 3;
  localparam int S          = SETTLE_CYC;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              sweep_i = 1'b0;
  logic [IDX_W-1:0]  ro_sel_i = '0;
  logic [WIN_W-1:0]  win_len_i = '0;
  logic              abort_i = 1'b0;
  logic [NUM_RO-1:0] ro_q_i = '0;
  logic [NUM_RO-1:0] ro_en_o;
  logic              busy_o, result_valid_o, ovf_o, done_o, err_o;
  logic [IDX_W-1:0]  result_idx_o;
  logic [CNT_W-1:0]  count_o;

  ro_meas_ctrl #(
    .NUM_RO(NUM_RO), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sweep_i(sweep_i),
    .ro_sel_i(ro_sel_i), .win_len_i(win_len_i), .abort_i(abort_i), .ro_q_i(ro_q_i),
    .ro_en_o(ro_en_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_idx_o(result_idx_o), .count_o(count_o), .ovf_o(ovf_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each RO is a square wave of half-period half[k] clocks, skewed off the clock edge.
  int half[NUM_RO] = '{5, 10, 20, 40, 2};
  always @(posedge clk) begin
    #3;
    for (int k = 0; k < NUM_RO; k++) ro_q_i[k] = (((cyc / half[k]) % 2) == 1);
  end

  typedef struct {
    int idx;
    int lo;
    int hi;
    int ovf;   // 2 = either value acceptable
    int done;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  function automatic int rising_edges(input int k, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if ((c % (2 * half[k])) == half[k]) n++;
    return n;
  endfunction

  task automatic expect_req(input bit sw, input int sel, input int win, input int t0);
    int l, nres, k, tru, lo, hi;
    exp_t e;
    if (!sw && sel >= NUM_RO) begin
      err_q.push_back(t0 + 1);
      return;
    end
    l    = S + win + 3;
    nres = sw ? NUM_RO : 1;
    for (int j = 0; j < nres; j++) begin
      k   = sw ? j : sel;
      tru = (win == 0) ? 0 : rising_edges(k, t0 + j * l + S + 1, t0 + j * l + S + win);
      lo  = (win == 0) ? 0 : ((tru > 0) ? tru - 1 : 0);
      hi  = (win == 0) ? 0 : tru + 1;
      e.idx  = k;
      e.lo   = (lo > CMAX) ? CMAX : lo;
      e.hi   = (hi > CMAX) ? CMAX : hi;
      e.ovf  = (lo > CMAX) ? 1 : ((hi <= CMAX) ? 0 : 2);
      e.done = (j == nres - 1) ? 1 : 0;
      e.cyc  = t0 + (j + 1) * l;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (result_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: idx %0d count %0d at cycle %0d, expected no result",
                   result_idx_o, count_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("res_cycle", cyc, e.cyc);
          check("res_idx", int'(result_idx_o), e.idx);
          check_range("res_count", int'(count_o), e.lo, e.hi);
          if (e.ovf != 2) check("res_ovf", int'(ovf_o), e.ovf);
          check("res_done", int'(done_o), e.done);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        check("res_missing_at_cycle", cyc, e.cyc);
      end
      if (err_o) begin
        if (err_q.size() == 0) check("unexpected_err", int'(err_o), 0);
        else                   check("err_cycle", cyc, err_q.pop_front());
      end
      if (err_q.size() > 0 && cyc > err_q[0]) check("err_missing_at_cycle", cyc, err_q.pop_front());
      check("done_qualified", int'(done_o & ~result_valid_o), 0);
      check("ro_en_onehot", int'($countones(ro_en_o) <= 1), 1);
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_start(input bit sw, input int sel, input int win, input bit push,
                          output int t0);
    sweep_i   = sw;
    ro_sel_i  = sel[IDX_W-1:0];
    win_len_i = win[WIN_W-1:0];
    start_i   = 1'b1;
    t0        = cyc;
    if (push) expect_req(sw, sel, win, t0);
    @(negedge clk);
    start_i = 1'b0;
    sweep_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o || exp_q.size() != 0 || err_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy_o) + exp_q.size() + err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ro_en"}, int'(ro_en_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_valid"}, int'(result_valid_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_err"}, int'(err_o), 0);
    check({tag, "_ovf"}, int'(ovf_o), 0);
    check({tag, "_count"}, int'(count_o), 0);
    check({tag, "_idx"}, int'(result_idx_o), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, saved_cnt, sel, win;
    bit sw;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single measurement of RO 2, window 100
    do_start(1'b0, 2, 100, 1'b1, t0);
    check("single_en_c1", int'(ro_en_o), 'b00100);
    check("single_busy_c1", int'(busy_o), 1);
    wait_cyc(t0 + 108);
    check("single_en_c108", int'(ro_en_o), 'b00100);
    wait_cyc(t0 + 109);
    check("single_en_c109", int'(ro_en_o), 0);
    wait_cyc(t0 + 111);
    check("single_busy_c111", int'(busy_o), 1);
    wait_cyc(t0 + 112);
    check("single_busy_c112", int'(busy_o), 0);
    wait_idle("single_drain");

    // Sweep of all ROs; RO 4 (period 4, 40 edges) saturates
    do_start(1'b1, 0, 160, 1'b1, t0);
    wait_idle("sweep_drain");

    // Saturation boundary on a single RO
    do_start(1'b0, 4, 100, 1'b1, t0);
    wait_idle("nosat_drain");
    do_start(1'b0, 4, 200, 1'b1, t0);
    wait_idle("sat_drain");

    // Abort in the middle of MEASURE
    saved_cnt = int'(count_o);
    do_start(1'b0, 1, 100, 1'b0, t0);
    wait_cyc(t0 + 50);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_en_c51", int'(ro_en_o), 0);
    check("abort_busy_c51", int'(busy_o), 0);
    repeat (80) @(negedge clk);
    check("abort_count_held", int'(count_o), saved_cnt);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_idle_busy", int'(busy_o), 0);

    // Rejected start and zero-length window
    do_start(1'b0, 5, 50, 1'b1, t0);
    check("reject_busy_c1", int'(busy_o), 0);
    wait_idle("reject5_drain");
    do_start(1'b0, 7, 50, 1'b1, t0);
    wait_idle("reject7_drain");
    do_start(1'b0, 3, 0, 1'b1, t0);
    wait_idle("win0_drain");

    // Reset mid-MEASURE, then a fresh request
    do_start(1'b0, 0, 100, 1'b0, t0);
    wait_cyc(t0 + 30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midreset");
    do_start(1'b0, 0, 60, 1'b1, t0);
    wait_idle("after_reset_drain");

    // Start while busy is ignored (no restart, no error)
    do_start(1'b0, 1, 40, 1'b1, t0);
    wait_cyc(t0 + 20);
    start_i  = 1'b1;
    sweep_i  = 1'b1;
    ro_sel_i = 3'd7;
    @(negedge clk);
    start_i = 1'b0;
    sweep_i = 1'b0;
    wait_idle("busy_start_drain");

    // Randomized requests
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < NUM_RO; k++) half[k] = int'($urandom_range(2, 12));
      sw  = ($urandom_range(0, 3) == 0);
      sel = int'($urandom_range(0, 7));
      win = int'($urandom_range(0, 80));
      do_start(sw, sel, win, 1'b1, t0);
      wait_idle("rand_drain");
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
